nn_dense_layer: RTL

Parametrised fully-connected neural-network layer engine, successor to the fixed-width `nn` layer block. Accepts one N_IN-element input vector per transaction and computes N_OUT outputs, each equal to bias[j] + Σ w[j][i]·x[i]. Arithmetic is signed fixed-point, with optional ReLU and output saturation. A single time-shared MAC computes the outputs serially. Weights and biases live in an internal register file loaded through a write port, and layers chain by connecting one instance's output handshake to the next instance's input handshake.

---
 rtl/nn_pkg.sv | 33 +++
 rtl/nn_dense_layer_mac.sv | 35 +++
 rtl/nn_dense_layer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared types and helpers for the dense-layer engine.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package nn_pkg;

   typedef enum logic [2:0] {IDLE, BIAS, MAC, STORE, OUT} nn_state_e;

   // Working width for the post-accumulate shift/ReLU/saturate step; holds any legal ACC_W.
   localparam int SAT_W = 64;

   // Flat register-file address of w[j][i]; i == n_in selects bias[j].
   function automatic int w_index(input int j, input int i, input int n_in);
      return j * (n_in + 1) + i;
   endfunction

   // Drop the fraction (floor), optionally clamp negatives to zero, then saturate to data_w bits.
   function automatic logic signed [SAT_W-1:0] sat_relu(input logic signed [SAT_W-1:0] acc,
                                                        input int frac_w,
                                                        input int data_w,
                                                        input logic relu);
      logic signed [SAT_W-1:0] r;
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      r  = acc >>> frac_w;
      hi = (SAT_W'(1) <<< (data_w - 1)) - SAT_W'(1);
      lo = ~hi;
      if (relu && (r < 0)) r = '0;
      if (r > hi)      r = hi;
      else if (r < lo) r = lo;
      return r;
   endfunction

endpackage

// File: rtl/nn_dense_layer_mac.sv
// Signed multiply-accumulate unit: bias preload then one product per cycle.
// Latency: result visible in acc one cycle after clear_load/accumulate.
// Backpressure: none; the controlling FSM paces it.
module nn_mac #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8,
   parameter int ACC_W  = 40
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_load,
   input  logic              accumulate,
   input  logic [DATA_W-1:0] bias,
   input  logic [DATA_W-1:0] w,
   input  logic [DATA_W-1:0] x,
   output logic [ACC_W-1:0]  acc
);

   logic signed [2*DATA_W-1:0] prod;
   logic [ACC_W-1:0]           prod_ext;
   logic [ACC_W-1:0]           bias_ext;

   assign prod     = $signed(w) * $signed(x);
   assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
   // Bias is a Q(FRAC_W) value; align it with the Q(2*FRAC_W) products.
   assign bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} << FRAC_W;

   // Accumulator: preload with the scaled bias, then add one full-width product per MAC cycle.
   always_ff @(posedge clk) begin
      if (!rst_n)          acc <= '0;
      else if (clear_load) acc <= bias_ext;
      else if (accumulate) acc <= acc + prod_ext;
   end

endmodule

// File: rtl/nn_dense_layer.sv
// Fully-connected layer: y[j] = bias[j] + sum_i w[j][i]*x[i], serial single-MAC evaluation.
// Latency: N_OUT*(N_IN+2) cycles from input accept to out_valid.
// Backpressure: holds out_valid/out_data until out_ready; in_ready low until the result drains.
module nn_dense_layer
   import nn_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8,
   parameter int N_IN   = 4,
   parameter int N_OUT  = 4,
   parameter int ACC_W  = 40,
   localparam int N_WORDS = N_OUT * (N_IN + 1),
   localparam int AW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    w_we,
   input  logic [AW-1:0]           w_addr,
   input  logic [DATA_W-1:0]       w_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N_IN*DATA_W-1:0]  in_data,
   input  logic                    relu_en,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [N_OUT*DATA_W-1:0] out_data,
   output logic                    busy
);

   localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
   localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   nn_state_e               state;
   logic [IW-1:0]           i;
   logic [JW-1:0]           j;
   logic [N_IN*DATA_W-1:0]  x_reg;
   logic                    mode_reg;
   logic [DATA_W-1:0]       wmem [N_WORDS];
   logic [AW-1:0]           rd_addr;
   logic [DATA_W-1:0]       rd_word;
   logic [ACC_W-1:0]        acc;
   logic signed [SAT_W-1:0] acc_ext;
   logic [DATA_W-1:0]       y_word;

   // BIAS reads the bias slot of neuron j; MAC reads w[j][i].
   assign rd_addr = AW'(w_index(int'(j), (state == BIAS) ? N_IN : int'(i), N_IN));
   assign rd_word = wmem[rd_addr];
   assign acc_ext = {{(SAT_W-ACC_W){acc[ACC_W-1]}}, acc};
   assign y_word  = DATA_W'(sat_relu(acc_ext, FRAC_W, DATA_W, mode_reg));

   nn_mac #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_load (state == BIAS),
      .accumulate (state == MAC),
      .bias       (rd_word),
      .w          (rd_word),
      .x          (x_reg[i*DATA_W +: DATA_W]),
      .acc        (acc)
   );

   // Weight/bias file: writable only while no computation is reading it; out-of-range writes dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < N_WORDS; k++) wmem[k] <= '0;
      end else if (w_we && (state == IDLE || state == OUT) && (int'(w_addr) < N_WORDS)) begin
         wmem[w_addr] <= w_data;
      end
   end

   // Control FSM with registered handshake outputs and the result register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         i         <= '0;
         j         <= '0;
         x_reg     <= '0;
         mode_reg  <= 1'b0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x_reg    <= in_data;
                  mode_reg <= relu_en;
                  j        <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= BIAS;
               end
            end
            BIAS: begin
               i     <= '0;
               state <= MAC;
            end
            MAC: begin
               if (i == IW'(N_IN - 1)) state <= STORE;
               else                    i     <= i + 1'b1;
            end
            STORE: begin
               out_data[j*DATA_W +: DATA_W] <= y_word;
               if (j == JW'(N_OUT - 1)) begin
                  out_valid <= 1'b1;
                  state     <= OUT;
               end else begin
                  j     <= j + 1'b1;
                  state <= BIAS;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
